// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared constants and types for the instruction fetch unit
package ifu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam int          PC_STEP          = 4;
  localparam int          FE_ADDR_W        = 32;
  localparam int          FE_INSTR_W       = 32;

  typedef struct packed {
    logic [FE_ADDR_W-1:0]  pc;
    logic [FE_INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_J,
    SEL_JR
  } redir_sel_e;

endpackage

// File: rtl/ifu_fetch_fifo.sv
// rtl/ifu_fetch_fifo.sv - DEPTH-entry prefetch FIFO with push/pop/flush and occupancy count
module ifu_fetch_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked by the count whenever it is stale.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/ifu_prefetch_queue.sv
// rtl/ifu_prefetch_queue.sv - fetch unit: PC register, redirect mux and prefetch queue toward decode
module ifu_prefetch_queue
  import ifu_pkg::*;
#(
  parameter int               ADDR_W   = 32,
  parameter int               INSTR_W  = 32,
  parameter int               DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [INSTR_W-1:0]       imem_rdata,
  input  logic                     redir_jr,
  input  logic [ADDR_W-1:0]        jr_target,
  input  logic                     redir_jump,
  input  logic [ADDR_W-1:0]        jump_target,
  input  logic                     redir_branch,
  input  logic [ADDR_W-1:0]        branch_target,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [ADDR_W-1:0]        dec_pc,
  output logic [INSTR_W-1:0]       dec_instr,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int            CW       = $clog2(DEPTH) + 1;
  localparam int            DW       = ADDR_W + INSTR_W;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] target;
  redir_sel_e        sel;
  logic              redirect, push, pop, empty;
  logic [DW-1:0]     head;

  always_comb begin
    sel = SEL_SEQ;
    if (redir_jr)          sel = SEL_JR;
    else if (redir_jump)   sel = SEL_J;
    else if (redir_branch) sel = SEL_BR;
  end

  always_comb begin
    target = '0;
    case (sel)
      SEL_JR:  target = jr_target;
      SEL_J:   target = jump_target;
      SEL_BR:  target = branch_target;
      default: target = '0;
    endcase
  end

  assign redirect = (sel != SEL_SEQ);
  assign pop      = dec_valid & dec_ready;
  // A full queue still accepts a fetch when the head leaves in the same cycle.
  assign push     = ~redirect & ((q_count < FULL_CNT) | pop);

  always_comb begin
    pc_d = pc_q;
    if (redirect)  pc_d = {target[ADDR_W-1:2], 2'b00};
    else if (push) pc_d = pc_q + ADDR_W'(PC_STEP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  ifu_fetch_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .wdata_i ({pc_q, imem_rdata}),
    .rdata_o (head),
    .empty_o (empty),
    .count_o (q_count)
  );

  assign imem_addr = pc_q;
  assign dec_valid = ~empty;
  assign dec_pc    = dec_valid ? head[DW-1:INSTR_W] : '0;
  assign dec_instr = dec_valid ? head[INSTR_W-1:0]  : '0;

endmodule

// File: tb/tb_ifu_prefetch_queue.sv
// tb/tb_ifu_prefetch_queue.sv - randomized self-checking bench with a queue-based fetch model
module tb_ifu_prefetch_queue;
  import ifu_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_rdata;
  logic        redir_jr, redir_jump, redir_branch;
  logic [31:0] jr_target, jump_target, branch_target;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_pc, dec_instr;
  logic [2:0]  q_count;

  int checks = 0;
  int errors = 0;

  fetch_entry_t mq[$];
  logic [31:0]  mpc;

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, ~a[31:16]} + a;
  endfunction

  assign imem_rdata = instr_of(imem_addr);

  ifu_prefetch_queue #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redir_jr      (redir_jr),
    .jr_target     (jr_target),
    .redir_jump    (redir_jump),
    .jump_target   (jump_target),
    .redir_branch  (redir_branch),
    .branch_target (branch_target),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .dec_pc        (dec_pc),
    .dec_instr     (dec_instr),
    .q_count       (q_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [31:0] epc, ein;
    epc = (mq.size() > 0) ? mq[0].pc : 32'h0;
    ein = (mq.size() > 0) ? mq[0].instr : 32'h0;
    check("dec_valid", 64'(dec_valid), 64'(mq.size() > 0));
    check("dec_pc", 64'(dec_pc), 64'(epc));
    check("dec_instr", 64'(dec_instr), 64'(ein));
    check("q_count", 64'(q_count), 64'(mq.size()));
    check("imem_addr", 64'(imem_addr), 64'(mpc));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check at the negedge.
  task automatic step(input logic rdy, input logic jr, input logic [31:0] jt,
                      input logic jp, input logic [31:0] jpt,
                      input logic br, input logic [31:0] bt);
    int  sz;
    logic pop;
    dec_ready = rdy; redir_jr = jr; jr_target = jt;
    redir_jump = jp; jump_target = jpt; redir_branch = br; branch_target = bt;
    sz  = mq.size();
    pop = (sz > 0) && rdy;
    if (jr || jp || br) begin
      mpc = (jr ? jt : jp ? jpt : bt) & 32'hFFFF_FFFC;
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (sz < DEPTH || pop) begin
        mq.push_back('{pc: mpc, instr: instr_of(mpc)});
        mpc = mpc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dec_ready = 1'b0; redir_jr = 1'b0; redir_jump = 1'b0; redir_branch = 1'b0;
    jr_target = '0; jump_target = '0; branch_target = '0;
    mq.delete();
    mpc = 32'h3000;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_model();
  endtask

  initial begin
    logic [31:0] t;
    reset = 1'b1;
    #1;
    do_reset();
    check("rst_valid", 64'(dec_valid), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'h3000);

    // Streaming with decode always ready
    step(1, 0, 0, 0, 0, 0, 0);
    check("t1_head0", 64'(dec_pc), 64'h3000);
    check("t1_instr0", 64'(dec_instr), 64'(instr_of(32'h3000)));
    step(1, 0, 0, 0, 0, 0, 0);
    check("t1_head1", 64'(dec_pc), 64'h3004);

    // Stall until full, then drain in order while refilling
    do_reset();
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0, 0);
    check("t2_count", 64'(q_count), 64'd4);
    check("t2_pc", 64'(imem_addr), 64'h3010);
    for (int i = 0; i < 5; i++) begin
      check("t2_drain", 64'(dec_pc), 64'(32'h3000 + 32'(4 * i)));
      step(1, 0, 0, 0, 0, 0, 0);
      check("t3_full", 64'(q_count), 64'd4);
      check("t3_pc", 64'(imem_addr), 64'(32'h3014 + 32'(4 * i)));
    end

    // Branch flush with three entries queued
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);
    check("t4_pre", 64'(q_count), 64'd3);
    step(1, 0, 0, 0, 0, 1, 32'h3100);
    check("t4_count", 64'(q_count), 64'd0);
    check("t4_valid", 64'(dec_valid), 64'd0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("t4_head", 64'(dec_pc), 64'h3100);

    // Priority and target alignment
    step(1, 1, 32'h3200, 1, 32'h3300, 1, 32'h3400);
    check("t5_prio", 64'(imem_addr), 64'h3200);
    step(1, 0, 0, 1, 32'h3300, 1, 32'h3400);
    check("t5_jump", 64'(imem_addr), 64'h3300);
    step(1, 1, 32'h3203, 0, 0, 0, 0);
    check("t5_align", 64'(imem_addr), 64'h3200);

    // Address wrap
    step(1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    check("t6_wrap_pre", 64'(imem_addr), 64'hFFFF_FFFC);
    step(1, 0, 0, 0, 0, 0, 0);
    check("t6_wrap", 64'(imem_addr), 64'h0);
    check("t6_wrap_head", 64'(dec_pc), 64'hFFFF_FFFC);

    // Randomized traffic with occasional mid-cycle async resets
    for (int n = 0; n < 400; n++) begin
      logic r, jr, jp, br;
      r  = ($urandom_range(0, 9) < 7);
      jr = ($urandom_range(0, 29) == 0);
      jp = ($urandom_range(0, 19) == 0);
      br = ($urandom_range(0, 11) == 0);
      t  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                       : (32'h3000 + 32'($urandom_range(0, 1023)));
      if ($urandom_range(0, 59) == 0) begin
        step(r, 0, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        redir_branch = 1'b1; branch_target = 32'h5000;
        #1;
        check("arst_valid", 64'(dec_valid), 64'd0);
        check("arst_pc", 64'(dec_pc), 64'd0);
        check("arst_instr", 64'(dec_instr), 64'd0);
        check("arst_count", 64'(q_count), 64'd0);
        check("arst_addr", 64'(imem_addr), 64'h3000);
        do_reset();
      end else begin
        step(r, jr, t ^ 32'h40, jp, t + 32'h80, br, t);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
